iw_load_fsm: RTL and testbench
==============================

# iw_load_fsm

Control stage directly upstream of the four-operand input-wrapper datapath (registers a, b, c, d loaded from a shared 16-bit bus with per-register write enables). Accepts a stream of 16-bit words over a valid/ready handshake and frames them into groups of four. It drives the datapath's shared data bus and write enables so that a, b, c and d are loaded in order. After each full group it holds the operands and presents them downstream with a valid/ready handshake, flagging framing errors.

## Interface
Parameters:
- W, 16, data width; must match the datapath bus width.
- CNT_W, 8, width of the completed-frame counter.
- REQUIRE_FIRST, 1, if 1 in_first is checked for framing; if 0 in_first is ignored and words are counted purely positionally.

Ports. Reset rst_n is asynchronous and active-low; clock is clk.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  W  incoming word.
- in_valid  in  1  in_data valid.
- in_first  in  1  current word is operand a (frame start).
- in_ready  out  1  block accepts the word this cycle.
- dataIn  out  W  bus to datapath; combinational copy of in_data.
- we_a, we_b, we_c, we_d  out  1 each  datapath write enables; at most one high per cycle.
- ops_valid  out  1  a..d hold a complete frame.
- ops_ready  in  1  downstream consumes the frame.
- frame_err  out  1  sticky framing-error flag.
- err_clr  in  1  synchronous clear of frame_err.
- frame_cnt  out  CNT_W  number of frames consumed downstream, modulo 2^CNT_W.

## Operation
- Input handshake: a word transfers on a rising edge where in_valid=1 and in_ready=1 (acc).
- in_ready is 1 in WAIT_A, LOAD_B, LOAD_C and LOAD_D, and 0 in HOLD.
- in_ready depends only on state, never on in_valid.
- we_x = acc and the state/first condition below. It is combinational, so the datapath register updates on the same edge as acc.
- State machine; reset state is WAIT_A:
  - WAIT_A, acc with in_first=1 (or REQUIRE_FIRST=0): assert we_a, go to LOAD_B.
  - WAIT_A, acc with in_first=0 and REQUIRE_FIRST=1: drop the word (no we), set frame_err, stay in WAIT_A.
  - LOAD_B, LOAD_C, LOAD_D, acc with in_first=0: assert we_b / we_c / we_d respectively. Advance to LOAD_C / LOAD_D / HOLD.
  - LOAD_B..LOAD_D, acc with in_first=1 and REQUIRE_FIRST=1: resynchronise. Assert we_a (not the positional enable), set frame_err, go to LOAD_B. The old partial frame is discarded.
  - No acc: state is unchanged.
  - HOLD: ops_valid=1. When ops_ready=1, go to WAIT_A on the next edge and increment frame_cnt.
- ops_valid is a registered state decode: high exactly in HOLD. It never drops without ops_ready.
- frame_cnt wraps from 2^CNT_W-1 to 0.
- frame_err: set has priority over err_clr in the same cycle. err_clr alone clears it on the next edge.

## Timing
- Reset (async assert, any state, mid-frame included): state is WAIT_A, ops_valid=0, frame_err=0, frame_cnt=0, all we_x=0, and in_ready=1 once rst_n is high.
- Datapath registers are also reset by rst_n, so no partial frame survives reset.
- Latency: the edge that accepts the 4th word (d) also writes d and enters HOLD. ops_valid is high from the following cycle.
- Minimum frame period is 5 cycles: 4 accepts plus 1 HOLD cycle with ops_ready held high.
- One bubble cycle occurs between frames, since in_ready=0 in HOLD.
- ops_ready sampled while not in HOLD is ignored.
- in_valid gaps may occur at any point in a frame; the state is held.

## Test plan
- Reset then words 0x1111(first), 0x2222, 0x3333, 0x4444 with ops_ready=1 throughout -> one-hot we_a, we_b, we_c, we_d on consecutive accept cycles. Next cycle ops_valid=1 with a..d=1111/2222/3333/4444. The cycle after, ops_valid=0 and frame_cnt=1.
- Same frame with ops_ready=0 for 6 cycles in HOLD -> ops_valid stays 1, in_ready stays 0, and a..d are unchanged.
- After 0xAAAA(first) and 0xBBBB, send 0xCCCC with in_first=1 -> we_a on that word, a=CCCC, frame_err=1, state LOAD_B. Then 3 more words complete a normal frame.
- From WAIT_A send 0x5555 with in_first=0 -> in_ready=1, no we, frame_err=1. Assert err_clr alone the following cycle -> frame_err=0.
- Assert rst_n low after 2 words, then release -> all outputs at reset values, and the next frame loads normally from a.
- Run 256 frames with CNT_W=8 -> frame_cnt wraps to 0. With REQUIRE_FIRST=0, in_first=1 on every word is ignored and positional loading continues.

Source files
------------

// File: rtl/iw_load_fsm_if.sv
// Handshake and datapath-bus bundle between the word stream, iw_load_fsm and
// the a/b/c/d operand datapath.
interface iw_load_fsm_if #(
    parameter int W     = 16,
    parameter int CNT_W = 8
);
    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_first;
    logic             in_ready;
    logic [W-1:0]     dataIn;
    logic             we_a;
    logic             we_b;
    logic             we_c;
    logic             we_d;
    logic             ops_valid;
    logic             ops_ready;
    logic             frame_err;
    logic             err_clr;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output in_data, in_valid, in_first, ops_ready, err_clr,
        input  in_ready, dataIn, we_a, we_b, we_c, we_d,
               ops_valid, frame_err, frame_cnt
    );

    modport slave (
        input  in_data, in_valid, in_first, ops_ready, err_clr,
        output in_ready, dataIn, we_a, we_b, we_c, we_d,
               ops_valid, frame_err, frame_cnt
    );
endinterface

// File: rtl/iw_load_fsm.sv
// Frames a 16-bit word stream into a/b/c/d operand loads for the input-wrapper
// datapath, then holds the group until downstream takes it.
module iw_load_fsm #(
    parameter int          W             = 16,
    parameter int          CNT_W         = 8,
    parameter int unsigned REQUIRE_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    iw_load_fsm_if.slave bus
);

    localparam logic STRICT = (REQUIRE_FIRST != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_WAIT_A = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_LOAD_C = 3'd2,
        ST_LOAD_D = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             in_ready_r;
    logic             ops_valid_r;
    logic             frame_err_r;
    logic [CNT_W-1:0] frame_cnt_r;
    logic [W-1:0]     data_s;
    logic             acc_s;
    logic             resync_s;
    logic             we_a_s;
    logic             we_b_s;
    logic             we_c_s;
    logic             we_d_s;
    logic             set_err_s;
    logic             consume_s;

    assign data_s   = bus.in_data;
    assign acc_s    = bus.in_valid & in_ready_r;
    // A frame-start marker mid-frame restarts loading at operand a.
    assign resync_s = acc_s & bus.in_first & STRICT;

    // Next-state, write-enable and error-set decode.
    always_comb begin
        state_nxt_s = state_r;
        we_a_s      = 1'b0;
        we_b_s      = 1'b0;
        we_c_s      = 1'b0;
        we_d_s      = 1'b0;
        set_err_s   = 1'b0;
        consume_s   = 1'b0;
        case (state_r)
            ST_WAIT_A: begin
                if (acc_s) begin
                    if (bus.in_first || !STRICT) begin
                        we_a_s      = 1'b1;
                        state_nxt_s = ST_LOAD_B;
                    end else begin
                        set_err_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_A;
                end
            end
            ST_LOAD_B: begin
                if (resync_s) begin
                    we_a_s      = 1'b1;
                    set_err_s   = 1'b1;
                    state_nxt_s = ST_LOAD_B;
                end else if (acc_s) begin
                    we_b_s      = 1'b1;
                    state_nxt_s = ST_LOAD_C;
                end else begin
                    state_nxt_s = ST_LOAD_B;
                end
            end
            ST_LOAD_C: begin
                if (resync_s) begin
                    we_a_s      = 1'b1;
                    set_err_s   = 1'b1;
                    state_nxt_s = ST_LOAD_B;
                end else if (acc_s) begin
                    we_c_s      = 1'b1;
                    state_nxt_s = ST_LOAD_D;
                end else begin
                    state_nxt_s = ST_LOAD_C;
                end
            end
            ST_LOAD_D: begin
                if (resync_s) begin
                    we_a_s      = 1'b1;
                    set_err_s   = 1'b1;
                    state_nxt_s = ST_LOAD_B;
                end else if (acc_s) begin
                    we_d_s      = 1'b1;
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_LOAD_D;
                end
            end
            ST_HOLD: begin
                if (bus.ops_ready) begin
                    consume_s   = 1'b1;
                    state_nxt_s = ST_WAIT_A;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_WAIT_A;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_WAIT_A;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // in_ready and ops_valid are decoded from the next state so they track state_r exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            ops_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s != ST_HOLD);
            ops_valid_r <= (state_nxt_s == ST_HOLD);
        end
    end

    // Sticky framing error; a new error wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_r <= 1'b0;
        end else if (set_err_s) begin
            frame_err_r <= 1'b1;
        end else if (bus.err_clr) begin
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= frame_err_r;
        end
    end

    // Count of frames taken downstream, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= {CNT_W{1'b0}};
        end else if (consume_s) begin
            frame_cnt_r <= frame_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.dataIn    = data_s;
    assign bus.we_a      = we_a_s;
    assign bus.we_b      = we_b_s;
    assign bus.we_c      = we_c_s;
    assign bus.we_d      = we_d_s;
    assign bus.ops_valid = ops_valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_iw_load_fsm.sv
// Drives a strict (REQUIRE_FIRST=1) and a positional (REQUIRE_FIRST=0) instance
// with shared stimulus and compares both against an operand-slot model.
module tb_iw_load_fsm;

    logic        clk;
    logic        rst_n;
    logic [15:0] tb_data;
    logic        tb_valid;
    logic        tb_first;
    logic        tb_ops_ready;
    logic        tb_err_clr;

    int n_checks;
    int n_fail;

    iw_load_fsm_if #(.W(16), .CNT_W(8)) if_s ();
    iw_load_fsm_if #(.W(16), .CNT_W(8)) if_l ();

    assign if_s.in_data   = tb_data;
    assign if_s.in_valid  = tb_valid;
    assign if_s.in_first  = tb_first;
    assign if_s.ops_ready = tb_ops_ready;
    assign if_s.err_clr   = tb_err_clr;
    assign if_l.in_data   = tb_data;
    assign if_l.in_valid  = tb_valid;
    assign if_l.in_first  = tb_first;
    assign if_l.ops_ready = tb_ops_ready;
    assign if_l.err_clr   = tb_err_clr;

    iw_load_fsm #(.W(16), .CNT_W(8), .REQUIRE_FIRST(1)) u_dut_strict (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s)
    );

    iw_load_fsm #(.W(16), .CNT_W(8), .REQUIRE_FIRST(0)) u_dut_loose (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand datapath registers fed by each DUT's bus and write enables.
    logic [15:0] dp_s [4];
    logic [15:0] dp_l [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) dp_s[k] <= 16'h0000;
        end else begin
            if (if_s.we_a) dp_s[0] <= if_s.dataIn;
            if (if_s.we_b) dp_s[1] <= if_s.dataIn;
            if (if_s.we_c) dp_s[2] <= if_s.dataIn;
            if (if_s.we_d) dp_s[3] <= if_s.dataIn;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) dp_l[k] <= 16'h0000;
        end else begin
            if (if_l.we_a) dp_l[0] <= if_l.dataIn;
            if (if_l.we_b) dp_l[1] <= if_l.dataIn;
            if (if_l.we_c) dp_l[2] <= if_l.dataIn;
            if (if_l.we_d) dp_l[3] <= if_l.dataIn;
        end
    end

    logic [3:0]  o_we  [2];
    logic        o_rdy [2];
    logic [15:0] o_din [2];
    logic        o_ov  [2];
    logic        o_err [2];
    logic [7:0]  o_cnt [2];

    assign o_we[0]  = {if_s.we_d, if_s.we_c, if_s.we_b, if_s.we_a};
    assign o_we[1]  = {if_l.we_d, if_l.we_c, if_l.we_b, if_l.we_a};
    assign o_rdy[0] = if_s.in_ready;
    assign o_rdy[1] = if_l.in_ready;
    assign o_din[0] = if_s.dataIn;
    assign o_din[1] = if_l.dataIn;
    assign o_ov[0]  = if_s.ops_valid;
    assign o_ov[1]  = if_l.ops_valid;
    assign o_err[0] = if_s.frame_err;
    assign o_err[1] = if_l.frame_err;
    assign o_cnt[0] = if_s.frame_cnt;
    assign o_cnt[1] = if_l.frame_cnt;

    // Model: m_pos = operands loaded in the current frame (4 = frame held).
    int          m_pos [2];
    logic [15:0] m_ops [2][4];
    logic        m_err [2];
    int          m_cnt [2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pos[m] = 0;
            m_err[m] = 1'b0;
            m_cnt[m] = 0;
            for (int k = 0; k < 4; k++) m_ops[m][k] = 16'h0000;
        end
    endtask

    // One clock cycle: drive at negedge, check, then advance the model past the posedge.
    task automatic step(input logic v, input logic f, input logic [15:0] d,
                        input logic r, input logic c);
        int          n_idx [2];
        logic        n_set [2];
        logic [3:0]  we_e;
        logic [15:0] dp_o;
        tb_valid = v; tb_first = f; tb_data = d; tb_ops_ready = r; tb_err_clr = c;
        #1;
        for (int m = 0; m < 2; m++) begin
            n_idx[m] = -1;
            n_set[m] = 1'b0;
            if (v && m_pos[m] != 4) begin
                if (m == 0 && f) begin
                    n_idx[m] = 0;
                    n_set[m] = (m_pos[m] != 0);
                end else if (m == 0 && m_pos[m] == 0) begin
                    n_set[m] = 1'b1;
                end else begin
                    n_idx[m] = m_pos[m];
                end
            end
            we_e = (n_idx[m] >= 0) ? (4'b0001 << n_idx[m]) : 4'b0000;
            check_val($sformatf("in_ready[%0d]", m), 32'(o_rdy[m]), 32'(m_pos[m] != 4));
            check_val($sformatf("we[%0d]", m), 32'(o_we[m]), 32'(we_e));
            check_val($sformatf("dataIn[%0d]", m), 32'(o_din[m]), 32'(d));
            check_val($sformatf("ops_valid[%0d]", m), 32'(o_ov[m]), 32'(m_pos[m] == 4));
            check_val($sformatf("frame_err[%0d]", m), 32'(o_err[m]), 32'(m_err[m]));
            check_val($sformatf("frame_cnt[%0d]", m), 32'(o_cnt[m]), 32'(m_cnt[m] % 256));
            for (int k = 0; k < 4; k++) begin
                dp_o = (m == 0) ? dp_s[k] : dp_l[k];
                check_val($sformatf("op%0d[%0d]", k, m), 32'(dp_o), 32'(m_ops[m][k]));
            end
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (n_idx[m] >= 0) begin
                m_ops[m][n_idx[m]] = d;
                m_pos[m] = n_idx[m] + 1;
            end else if (m_pos[m] == 4 && r) begin
                m_pos[m] = 0;
                m_cnt[m] = m_cnt[m] + 1;
            end
            if (n_set[m]) m_err[m] = 1'b1;
            else if (c)   m_err[m] = 1'b0;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset issued between clock edges, held for two cycles.
    task automatic reset_dut();
        tb_valid = 1'b0; tb_first = 1'b0; tb_data = 16'h0000;
        tb_ops_ready = 1'b0; tb_err_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            check_val($sformatf("rst_ops_valid[%0d]", m), 32'(o_ov[m]), 32'd0);
            check_val($sformatf("rst_frame_err[%0d]", m), 32'(o_err[m]), 32'd0);
            check_val($sformatf("rst_frame_cnt[%0d]", m), 32'(o_cnt[m]), 32'd0);
            check_val($sformatf("rst_we[%0d]", m), 32'(o_we[m]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [15:0] base, input int hold_cycles);
        for (int k = 0; k < 4; k++) step(1'b1, (k == 0), base + 16'(k), 1'b0, 1'b0);
        for (int h = 0; h < hold_cycles; h++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        tb_valid = 1'b0; tb_first = 1'b0; tb_data = 16'h0000;
        tb_ops_ready = 1'b0; tb_err_clr = 1'b0;
        model_reset();
        @(negedge clk);
        reset_dut();

        // Basic frame with ops_ready high throughout.
        step(1'b1, 1'b1, 16'h1111, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'h2222, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'h3333, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'h4444, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check_val("frame_cnt_one", 32'(o_cnt[0]), 32'd1);

        // Stalled hold for six cycles.
        send_frame(16'h1111, 6);

        // Mid-frame resynchronisation, then completion.
        step(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'hBBBB, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'hCCCC, 1'b0, 1'b0);
        check_val("resync_err", 32'(o_err[0]), 32'd1);
        check_val("resync_a", 32'(dp_s[0]), 32'h0000CCCC);
        step(1'b1, 1'b0, 16'hDDDD, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'hEEEE, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Stray non-first word in WAIT_A, then clear.
        step(1'b1, 1'b0, 16'h5555, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        check_val("err_cleared", 32'(o_err[0]), 32'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Every word flagged first: positional instance ignores it.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 16'h7000 + 16'(k), 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Reset in the middle of a frame.
        step(1'b1, 1'b1, 16'h9001, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h9002, 1'b0, 1'b0);
        reset_dut();
        send_frame(16'h6660, 0);

        // Randomised traffic including framing errors and clears.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 16'($urandom),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0));
        end

        // 256 clean frames wrap the 8-bit counter back to zero.
        reset_dut();
        for (int fr = 0; fr < 256; fr++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 16'($urandom), 1'b0, 1'b0);
                step(1'b1, (k == 0), 16'($urandom), 1'b0, 1'b0);
            end
            for (int h = 0; h < int'($urandom_range(0, 2)); h++)
                step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
            step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_val("wrap_strict", 32'(o_cnt[0]), 32'd0);
        check_val("wrap_loose", 32'(o_cnt[1]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
